mix_columns_step: RTL
=====================

// Module: mix_columns_step
// PURPOSE
//  AES MixColumns round stage; sits directly downstream of shiftrowsstep and consumes its 128-bit state.
//  Multiplies each 4-byte state column by the fixed GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
//  Iterative: processes COLS_PER_CYCLE columns per clock under the level start/finish handshake used by the round stages.
//  Optionally fuses AddRoundKey on the result.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns transformed per clock; legal values 1, 2, 4; other values are an elaboration error.
// PORTS
//  clk             input   1    clock; all state changes on posedge.
//  rst             input   1    asynchronous, active-high reset.
//  start           input   1    level request; hold high until finish is seen, drop to release.
//  in              input   128  state; byte k = in[8k+7:8k]; column c = bytes 4c..4c+3; row r = byte 4c+r.
//  key             input   128  round key, same byte layout; used only with ADD_ROUND_KEY_EN.
//  finish          output  1    result valid and held.
//  mixcolumnsstep  output  128  transformed state, same byte layout.
// BEHAVIOUR
//  Reset: state IDLE, finish=0, mixcolumnsstep=0, column counter=0, latched state=0; takes effect immediately, mid-run included.
//  FSM states IDLE, RUN, DONE:
//   IDLE: on posedge with start=1, latch in (and key), counter=0, go to RUN.
//   RUN: each cycle write columns counter..counter+COLS_PER_CYCLE-1 of mixcolumnsstep; counter += COLS_PER_CYCLE.
//        After writing column 3, go to DONE and set finish=1 on that same edge.
//        start=0 in RUN: abort to IDLE; finish stays 0; partially written output is don't-care.
//   DONE: finish=1, output held stable; start=0 -> IDLE, finish=0 on that edge; output keeps its value.
//  Latency: finish rises 4/COLS_PER_CYCLE edges after the IDLE edge that sampled start=1 (1-column config: 4).
//  Input is latched, so in/key may change after the IDLE capture edge without effect.
//  start held high across DONE never retriggers; start must go low for at least one cycle before the next run.
//  GF arithmetic: xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00); 3*b = xtime(b)^b; all adds are XOR; no widths beyond 8 bits.
//  Output bits are only guaranteed while finish=1.
// CONFIGURATION
//  `ADD_ROUND_KEY_EN defined: each column written is mix(col) ^ latched key column (fused AddRoundKey); latency unchanged.
//  Not defined: pure MixColumns; key port unused (no latch flops for it).
// STRUCTURE
//  aes_pkg: typedef enum {IDLE,RUN,DONE} mc_state_t; NB_COLS=4; function xtime; function gf_mul3.
//  Sub-module mix_single_column: combinational 32-bit column in -> 32-bit column out.
//  Instantiate mix_single_column COLS_PER_CYCLE times via generate.
// TESTING
//  1 in=128'hc6c6c6c6_01010101_5c220af2_455313db, start=1 -> after 4 edges finish=1, mixcolumnsstep=128'hc6c6c6c6_01010101_9d58dc9f_bca14d8e.
//  2 in=128'he598271ef11141b8ae52b4e0305dbfd4 (FIPS-197 rnd1) -> mixcolumnsstep=128'h4c2606287ad3f8489a19cbe0e5816604.
//  3 Same as 2 with `ADD_ROUND_KEY_EN, key=128'h05766c2a3939a323b12c548817fefaa0 -> mixcolumnsstep=128'h49506a0243ea5b6b2b359f68f27f9ca4.
//  4 Drop start after 2 RUN cycles, re-raise with vector 1 -> no finish pulse from the aborted run; the fresh run completes with the vector-1 result.
//  5 Assert rst mid-RUN -> finish=0 and mixcolumnsstep=0 immediately; after release, vector 2 run passes.
//  6 Repeat vectors 1-2 with COLS_PER_CYCLE=2 and 4 -> latency 2 and 1 edges, identical results; start held high in DONE produces no retrigger.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// Module : aes_pkg
// Brief  : Shared types and GF(2^8) helpers for the AES round stages.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_pkg;

    localparam int NB_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Multiply by x modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mix_single_column.sv
// ============================================================================
// Module : mix_single_column
// Brief  : Combinational MixColumns transform of one 4-byte column (row r = byte r).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_b0;
    logic [7:0] w_b1;
    logic [7:0] w_b2;
    logic [7:0] w_b3;

    assign w_b0 = i_col[7:0];
    assign w_b1 = i_col[15:8];
    assign w_b2 = i_col[23:16];
    assign w_b3 = i_col[31:24];

    // Circulant matrix rows [2 3 1 1], [1 2 3 1], [1 1 2 3], [3 1 1 2].
    assign o_col[7:0]   = xtime(w_b0)   ^ gf_mul3(w_b1) ^ w_b2          ^ w_b3;
    assign o_col[15:8]  = w_b0          ^ xtime(w_b1)   ^ gf_mul3(w_b2) ^ w_b3;
    assign o_col[23:16] = w_b0          ^ w_b1          ^ xtime(w_b2)   ^ gf_mul3(w_b3);
    assign o_col[31:24] = gf_mul3(w_b0) ^ w_b1          ^ w_b2          ^ xtime(w_b3);

endmodule

`default_nettype wire

// File: rtl/mix_columns_step.sv
// ============================================================================
// Module : mix_columns_step
// Brief  : Iterative AES MixColumns stage, COLS_PER_CYCLE columns per clock,
//          level start/finish handshake. Define ADD_ROUND_KEY_EN to fuse
//          AddRoundKey into each written column.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mix_columns_step
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         finish,
    output logic [127:0] mixcolumnsstep
);

    if ((COLS_PER_CYCLE != 1) && (COLS_PER_CYCLE != 2) && (COLS_PER_CYCLE != 4)) begin : g_bad_cols
        $error("mix_columns_step: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // Counter advance wraps modulo NB_COLS; the 4-column build steps by 0.
    localparam logic [1:0] c_STEP     = 2'(COLS_PER_CYCLE % NB_COLS);
    localparam logic [1:0] c_LAST_IDX = 2'(NB_COLS - COLS_PER_CYCLE);

    mc_state_t    r_fsm;
    logic [1:0]   r_col_idx;
    logic [127:0] r_data;
    logic [127:0] r_out;
    logic         r_finish;

    logic [1:0]   w_col_idx [COLS_PER_CYCLE];
    logic [31:0]  w_col_mix [COLS_PER_CYCLE];
    logic [31:0]  w_col_res [COLS_PER_CYCLE];

`ifdef ADD_ROUND_KEY_EN
    logic [127:0] r_key;
`else
    logic         w_unused_key;
    assign w_unused_key = ^key;
`endif

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        assign w_col_idx[g] = r_col_idx + 2'(g);

        mix_single_column u_mix (
            .i_col (r_data[{w_col_idx[g], 5'd0} +: 32]),
            .o_col (w_col_mix[g])
        );

`ifdef ADD_ROUND_KEY_EN
        assign w_col_res[g] = w_col_mix[g] ^ r_key[{w_col_idx[g], 5'd0} +: 32];
`else
        assign w_col_res[g] = w_col_mix[g];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm     <= IDLE;
            r_col_idx <= 2'd0;
            r_data    <= '0;
            r_out     <= '0;
            r_finish  <= 1'b0;
`ifdef ADD_ROUND_KEY_EN
            r_key     <= '0;
`endif
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (start) begin
                        r_data    <= in;
`ifdef ADD_ROUND_KEY_EN
                        r_key     <= key;
`endif
                        r_col_idx <= 2'd0;
                        r_fsm     <= RUN;
                    end
                end
                RUN: begin
                    if (!start) begin
                        r_col_idx <= 2'd0;
                        r_fsm     <= IDLE;
                    end else begin
                        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                            r_out[{w_col_idx[i], 5'd0} +: 32] <= w_col_res[i];
                        end
                        r_col_idx <= r_col_idx + c_STEP;
                        if (r_col_idx == c_LAST_IDX) begin
                            r_fsm    <= DONE;
                            r_finish <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Hold the result; a new run needs start to drop first.
                    if (!start) begin
                        r_fsm    <= IDLE;
                        r_finish <= 1'b0;
                    end
                end
                default: begin
                    r_fsm    <= IDLE;
                    r_finish <= 1'b0;
                end
            endcase
        end
    end

    assign finish         = r_finish;
    assign mixcolumnsstep = r_out;

endmodule

`default_nettype wire
